// File: rtl/pb_field_decoder.sv
// pb_field_decoder: protobuf wire-format field splitter.
// It decodes varint tags into a field number and a wire type, then passes
// the field payload straight through as a byte stream with a last flag.
// Length prefixes are consumed and are not forwarded. After any protocol
// violation the block stays in a sticky draining error state until reset.
module pb_field_decoder #(
    parameter int FIELD_ID_W    = 29,
    parameter int MAX_TAG_BYTES = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid,
    output logic                  byte_rdy,
    input  logic                  byte_last,
    output logic [FIELD_ID_W-1:0] field_id_o,
    output logic [2:0]            wire_type_o,
    output logic                  field_id_valid,
    input  logic                  field_id_rdy,
    output logic [7:0]            data_o,
    output logic                  data_valid,
    input  logic                  data_rdy,
    output logic                  data_last,
    output logic                  err_o
);
    // The accumulator must hold every prefix byte, the tag slice and a 32-bit length.
    localparam int ACC_RAW = 7 * MAX_TAG_BYTES;
    localparam int ACC_A   = (ACC_RAW > FIELD_ID_W + 3) ? ACC_RAW : FIELD_ID_W + 3;
    localparam int ACC_W   = (ACC_A > 32) ? ACC_A : 32;
    localparam int NB_W    = $clog2(MAX_TAG_BYTES + 1);

    typedef enum logic [2:0] {
        S_TAG, S_EMIT, S_LEN, S_PAY_VARINT, S_PAY_FIXED, S_PAY_LEN, S_ERROR
    } state_e;

    state_e                state_q;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [NB_W-1:0]       nb_q;
    logic [31:0]           cnt_q;
    logic [FIELD_ID_W-1:0] fid_q, fid_d;
    logic [2:0]            wt_q, wt_d;
    logic [31:0]           len_d;
    logic                  fvld_q, err_q, rdy_en_q;
    logic                  in_pay, byte_acc, pfx_end, pfx_over, bad_tag, to_err;

    assign in_pay   = (state_q == S_PAY_VARINT) || (state_q == S_PAY_FIXED) ||
                      (state_q == S_PAY_LEN);
    assign byte_acc = byte_valid && byte_rdy;

    // Little-endian 7-bit varint accumulation shared by the tag and length prefixes
    assign acc_d    = acc_q | (ACC_W'(byte_i[6:0]) << (7 * nb_q));
    assign fid_d    = acc_d[FIELD_ID_W+2:3];
    assign wt_d     = acc_d[2:0];
    assign len_d    = acc_d[31:0];
    assign pfx_end  = !byte_i[7];
    // The last allowed prefix byte still carrying a continuation bit means the prefix is too long
    assign pfx_over = byte_i[7] && (nb_q == NB_W'(MAX_TAG_BYTES - 1));
    assign bad_tag  = (fid_d == '0) ||
                      !((wt_d == 3'd0) || (wt_d == 3'd1) || (wt_d == 3'd2) || (wt_d == 3'd5));

    assign field_id_o     = fid_q;
    assign wire_type_o    = wt_q;
    assign field_id_valid = fvld_q;
    assign err_o          = err_q;
    assign data_o         = byte_i;
    assign data_valid     = in_pay && byte_valid;

    // Input ready: payload states follow the consumer, EMIT blocks, the other states always take bytes
    always_comb begin
        byte_rdy = 1'b0;
        if (rdy_en_q) begin
            case (state_q)
                S_EMIT:                                 byte_rdy = 1'b0;
                S_PAY_VARINT, S_PAY_FIXED, S_PAY_LEN:   byte_rdy = data_rdy;
                default:                                byte_rdy = 1'b1;
            endcase
        end
    end

    // Last payload beat: a varint ends on a clear continuation bit, counted payloads end on count 1
    always_comb begin
        data_last = 1'b0;
        case (state_q)
            S_PAY_VARINT:           data_last = !byte_i[7];
            S_PAY_FIXED, S_PAY_LEN: data_last = (cnt_q == 32'd1);
            default:                data_last = 1'b0;
        endcase
    end

    // Protocol violations. byte_last is legal only on a final payload beat or on a zero length prefix.
    always_comb begin
        to_err = 1'b0;
        if (byte_acc) begin
            case (state_q)
                S_TAG:        to_err = pfx_over || byte_last || (pfx_end && bad_tag);
                S_LEN:        to_err = pfx_over || (byte_last && !(pfx_end && len_d == 32'd0));
                S_PAY_VARINT: to_err = !data_last && (byte_last || cnt_q == 32'd1);
                S_PAY_FIXED,
                S_PAY_LEN:    to_err = !data_last && byte_last;
                default:      to_err = 1'b0;
            endcase
        end
    end

    // Main control FSM with the registered field outputs and the sticky error flag
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_TAG;
            acc_q    <= '0;
            nb_q     <= '0;
            cnt_q    <= '0;
            fid_q    <= '0;
            wt_q     <= '0;
            fvld_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (to_err) begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_TAG: if (byte_acc) begin
                        acc_q <= acc_d;
                        nb_q  <= nb_q + NB_W'(1);
                        if (pfx_end) begin
                            fid_q   <= fid_d;
                            wt_q    <= wt_d;
                            fvld_q  <= 1'b1;
                            state_q <= S_EMIT;
                        end
                    end
                    S_EMIT: if (field_id_rdy) begin
                        fvld_q <= 1'b0;
                        case (wt_q)
                            3'd0: begin state_q <= S_PAY_VARINT; cnt_q <= 32'd10; end
                            3'd1: begin state_q <= S_PAY_FIXED;  cnt_q <= 32'd8;  end
                            3'd5: begin state_q <= S_PAY_FIXED;  cnt_q <= 32'd4;  end
                            // Only type 2 can remain; other types were rejected at the tag
                            default: begin
                                state_q <= S_LEN;
                                acc_q   <= '0;
                                nb_q    <= '0;
                            end
                        endcase
                    end
                    S_LEN: if (byte_acc) begin
                        acc_q <= acc_d;
                        nb_q  <= nb_q + NB_W'(1);
                        if (pfx_end) begin
                            acc_q <= '0;
                            nb_q  <= '0;
                            if (len_d == 32'd0) begin
                                state_q <= S_TAG;
                            end else begin
                                state_q <= S_PAY_LEN;
                                cnt_q   <= len_d;
                            end
                        end
                    end
                    S_PAY_VARINT, S_PAY_FIXED, S_PAY_LEN: if (byte_acc) begin
                        cnt_q <= cnt_q - 32'd1;
                        if (data_last) begin
                            state_q <= S_TAG;
                            acc_q   <= '0;
                            nb_q    <= '0;
                        end
                    end
                    // S_ERROR drains input; only reset leaves it
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pb_field_decoder.sv
// Testbench for pb_field_decoder: directed protocol scenarios followed by random
// messages. A protobuf encoder model produces the expected fields and beats,
// and a monitor compares them against the DUT outputs.
module tb_pb_field_decoder;
  localparam int FW = 29;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [7:0]    byte_i;
  logic          byte_valid, byte_rdy, byte_last;
  logic [FW-1:0] field_id_o;
  logic [2:0]    wire_type_o;
  logic          field_id_valid, field_id_rdy;
  logic [7:0]    data_o;
  logic          data_valid, data_rdy, data_last, err_o;

  pb_field_decoder #(.FIELD_ID_W(FW), .MAX_TAG_BYTES(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .byte_i(byte_i), .byte_valid(byte_valid),
    .byte_rdy(byte_rdy), .byte_last(byte_last), .field_id_o(field_id_o),
    .wire_type_o(wire_type_o), .field_id_valid(field_id_valid), .field_id_rdy(field_id_rdy),
    .data_o(data_o), .data_valid(data_valid), .data_rdy(data_rdy), .data_last(data_last),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] b; bit last; } sb_t;
  typedef struct { logic [FW-1:0] fid; logic [2:0] wt; } ef_t;

  sb_t stream[$];
  ef_t exp_f[$];
  sb_t exp_d[$];
  int  total = 0;
  int  bad   = 0;
  bit  rand_bp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_f(input logic [FW-1:0] fid, input logic [2:0] wt);
    ef_t e; e.fid = fid; e.wt = wt; exp_f.push_back(e);
  endtask

  task automatic push_d(input logic [7:0] b, input bit l);
    sb_t e; e.b = b; e.last = l; exp_d.push_back(e);
  endtask

  task automatic put(input logic [7:0] b, input bit l);
    sb_t e; e.b = b; e.last = l; stream.push_back(e);
  endtask

  // Standard varint encoding; optionally record each byte as an expected data beat
  task automatic enc(input logic [63:0] v, input bit as_data);
    logic [63:0] r;
    logic [7:0]  b;
    r = v;
    do begin
      b = {1'b0, r[6:0]};
      r = r >> 7;
      if (r != 0) b[7] = 1'b1;
      put(b, 1'b0);
      if (as_data) push_d(b, r == 0);
    end while (r != 0);
  endtask

  task automatic send(input logic [7:0] b, input bit l);
    int t;
    t = 0;
    byte_i = b; byte_last = l; byte_valid = 1'b1;
    do begin @(negedge clk_i); t++; end while (!byte_rdy && t < 200);
    if (!byte_rdy) chk("send_timeout", 64'(t), 64'd0);
    @(posedge clk_i); #1;
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic send_stream(input bit gaps);
    while (stream.size() > 0) begin
      sb_t e;
      e = stream.pop_front();
      if (gaps && ($urandom % 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
      send(e.b, e.last);
    end
  endtask

  task automatic do_reset();
    chk("drain", 64'(exp_f.size() + exp_d.size()), 64'd0);
    @(posedge clk_i); #3;
    reset_i = 1'b0; byte_valid = 1'b1; byte_i = 8'h63; byte_last = 1'b0;
    #1;
    chk("rst_byte_rdy", byte_rdy, 0);
    chk("rst_fid_valid", field_id_valid, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data_last", data_last, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fid", field_id_o, 0);
    chk("rst_wt", wire_type_o, 0);
    byte_valid = 1'b0;
    exp_f.delete(); exp_d.delete(); stream.delete();
    repeat (2) @(posedge clk_i);
    #2; reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_byte_rdy", byte_rdy, 1);
  endtask

  // Random message: 1-4 fields of legal types, byte_last on the final byte
  task automatic gen_msg();
    int nf;
    nf = $urandom_range(1, 4);
    for (int f = 0; f < nf; f++) begin
      int          k, n, w;
      logic [31:0] fid;
      logic [2:0]  wt;
      logic [63:0] v;
      logic [7:0]  b;
      w  = $urandom_range(0, 3);
      wt = (w == 3) ? 3'd5 : 3'(w);
      k  = $urandom_range(1, FW);
      fid = $urandom & ((32'd1 << k) - 32'd1);
      if (fid == 0) fid = 32'd1;
      push_f(fid[FW-1:0], wt);
      enc(64'(fid) * 64'd8 + 64'(wt), 1'b0);
      case (wt)
        3'd0: begin
          v = {$urandom, $urandom} >> $urandom_range(0, 63);
          enc(v, 1'b1);
        end
        3'd2: begin
          n = $urandom_range(0, 9);
          if (n >= 7) n = 0;
          else if (n == 6) n = $urandom_range(128, 131);
          else n = n + 1;
          enc(64'(n), 1'b0);
          for (int i = 0; i < n; i++) begin
            b = 8'($urandom); put(b, 1'b0); push_d(b, i == n - 1);
          end
        end
        default: begin
          n = (wt == 3'd1) ? 8 : 4;
          for (int i = 0; i < n; i++) begin
            b = 8'($urandom); put(b, 1'b0); push_d(b, i == n - 1);
          end
        end
      endcase
    end
    stream[stream.size() - 1].last = 1'b1;
  endtask

  // Random consumer backpressure
  initial forever begin
    @(posedge clk_i); #1;
    if (rand_bp) begin
      field_id_rdy = ($urandom % 4) != 0;
      data_rdy     = ($urandom % 4) != 0;
    end
  end

  // Monitor: pop the scoreboard on every output handshake, check a held field stays put
  initial begin
    bit            pend;
    logic [FW-1:0] pf;
    logic [2:0]    pw;
    ef_t           ef;
    sb_t           ed;
    pend = 1'b0; pf = '0; pw = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("fid_hold_valid", field_id_valid, 1);
          chk("fid_hold_value", {field_id_o, wire_type_o}, {pf, pw});
        end
        pend = field_id_valid && !field_id_rdy;
        pf = field_id_o; pw = wire_type_o;
        if (field_id_valid && field_id_rdy) begin
          if (exp_f.size() == 0) chk("unexpected_field", {field_id_o, wire_type_o}, 0);
          else begin
            ef = exp_f.pop_front();
            chk("field_id", field_id_o, ef.fid);
            chk("wire_type", wire_type_o, ef.wt);
          end
        end
        if (data_valid && data_rdy) begin
          if (exp_d.size() == 0) chk("unexpected_data", {1'b1, data_o}, 0);
          else begin
            ed = exp_d.pop_front();
            chk("data", data_o, ed.b);
            chk("data_last", data_last, ed.last);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0; byte_i = '0; byte_valid = 1'b0; byte_last = 1'b0;
    field_id_rdy = 1'b1; data_rdy = 1'b1;
    do_reset();

    // varint field
    push_f(1, 0); push_d(8'h96, 0); push_d(8'h01, 1);
    put(8'h08, 0); put(8'h96, 0); put(8'h01, 1);
    send_stream(0);
    chk("varint_err", err_o, 0);

    // length-delimited, then zero-length field ending the message
    push_f(2, 2); push_d(8'h61, 0); push_d(8'h62, 0); push_d(8'h63, 1);
    push_f(3, 2);
    put(8'h12, 0); put(8'h03, 0); put(8'h61, 0); put(8'h62, 0); put(8'h63, 0);
    put(8'h1A, 0); put(8'h00, 1);
    send_stream(0);
    chk("len_err", err_o, 0);

    // multi-byte tag
    push_f(31, 0); push_d(8'h00, 1);
    put(8'hF8, 0); put(8'h01, 0); put(8'h00, 0);
    send_stream(0);

    // field and payload backpressure
    field_id_rdy = 1'b0;
    push_f(1, 5);
    push_d(8'h11, 0); push_d(8'h22, 0); push_d(8'h33, 0); push_d(8'h44, 1);
    send(8'h0D, 0);
    byte_i = 8'h11; byte_valid = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_fid_valid", field_id_valid, 1);
      chk("bp_fid", field_id_o, 1);
      chk("bp_wt", wire_type_o, 5);
      chk("bp_byte_rdy", byte_rdy, 0);
    end
    @(posedge clk_i); #1;
    field_id_rdy = 1'b1;
    send(8'h11, 0); send(8'h22, 0);
    data_rdy = 1'b0; byte_i = 8'h33; byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_pay_byte_rdy", byte_rdy, 0);
      chk("bp_pay_data_valid", data_valid, 1);
      chk("bp_pay_data", data_o, 8'h33);
    end
    @(posedge clk_i); #1;
    data_rdy = 1'b1;
    send(8'h33, 0); send(8'h44, 1);
    chk("bp_err", err_o, 0);

    // bad wire type
    do_reset();
    send(8'h0B, 0);
    chk("wt3_err", err_o, 1);
    chk("wt3_fid_valid", field_id_valid, 0);
    chk("wt3_byte_rdy", byte_rdy, 1);
    send(8'h08, 0); send(8'h96, 0); send(8'h01, 1);
    chk("wt3_sticky", err_o, 1);

    // byte_last before the payload ends
    do_reset();
    push_f(2, 2); push_d(8'h61, 0);
    put(8'h12, 0); put(8'h05, 0); put(8'h61, 1);
    send_stream(0);
    chk("early_last_err", err_o, 1);

    // field number zero
    do_reset();
    send(8'h00, 0);
    chk("fid0_err", err_o, 1);

    // six-byte tag
    do_reset();
    send(8'h88, 0); repeat (3) send(8'h80, 0);
    chk("long_tag_pre", err_o, 0);
    send(8'h80, 0); send(8'h01, 0);
    chk("long_tag_err", err_o, 1);

    // varint payload longer than ten bytes
    do_reset();
    push_f(1, 0);
    repeat (10) push_d(8'h80, 0);
    send(8'h08, 0);
    repeat (9) send(8'h80, 0);
    chk("varint10_pre", err_o, 0);
    send(8'h80, 0);
    chk("varint10_err", err_o, 1);

    // six-byte length prefix
    do_reset();
    push_f(2, 2);
    send(8'h12, 0); repeat (5) send(8'h80, 0); send(8'h01, 0);
    chk("long_len_err", err_o, 1);

    // reset during a length-delimited payload, then a fresh field
    do_reset();
    push_f(2, 2); push_d(8'h61, 0); push_d(8'h62, 0);
    put(8'h12, 0); put(8'h05, 0); put(8'h61, 0); put(8'h62, 0);
    send_stream(0);
    do_reset();
    push_f(1, 0); push_d(8'h01, 1);
    put(8'h08, 0); put(8'h01, 1);
    send_stream(0);
    chk("after_rst_err", err_o, 0);

    // random messages with random gaps and backpressure
    do_reset();
    rand_bp = 1'b1;
    for (int m = 0; m < 40; m++) begin
      gen_msg();
      send_stream(1);
    end
    rand_bp = 1'b0;
    field_id_rdy = 1'b1; data_rdy = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rand_err", err_o, 0);
    chk("rand_drain", 64'(exp_f.size() + exp_d.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
